// File: rtl/ghostbus_arb_pkg.sv
// Shared types for the two-port ghostbus arbiter: FSM states, requester
// identity and the read-latency counter width.
package ghostbus_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RWAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/ghostbus_rr_grant2.sv
// Combinational two-way round-robin pick; the last-winner pointer is
// registered by the caller.
module ghostbus_rr_grant2
  import ghostbus_arb_pkg::*;
(
  input  logic   i_a_valid,
  input  logic   i_b_valid,
  input  owner_t i_last,
  output logic   o_grant_a,
  output logic   o_grant_b
);

  // On a tie the port that did not win last time goes first.
  assign o_grant_a = i_a_valid & (~i_b_valid | (i_last == OWN_B));
  assign o_grant_b = i_b_valid & (~i_a_valid | (i_last == OWN_A));

endmodule

// File: rtl/ghostbus_arbiter.sv
// Shares one ghostbus host port between requesters A and B: one transaction
// at a time, one-cycle strobes, fixed read latency, response to the issuer.
module ghostbus_arbiter
  import ghostbus_arb_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
)
(
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  input  logic          a_valid,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata
);

  localparam logic [CNT_W-1:0] LAT_M1 = (RD_LAT == 0) ? '0 : CNT_W'(RD_LAT - 1);

  state_t           r_state;
  state_t           w_state_next;
  owner_t           r_last;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_a_rdata;
  logic [DW-1:0]    r_b_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_sample;

  ghostbus_rr_grant2 u_grant (
    .i_a_valid (a_valid),
    .i_b_valid (b_valid),
    .i_last    (r_last),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  // Ready is suppressed while reset is held so no transfer can appear to occur.
  assign a_ready  = (r_state == ST_IDLE) & w_grant_a & gb_rst_n;
  assign b_ready  = (r_state == ST_IDLE) & w_grant_b & gb_rst_n;
  assign gb_addr  = r_addr;
  assign gb_wdata = r_wdata;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sample     = 1'b0;
    gb_wen       = 1'b0;
    gb_rstb      = 1'b0;
    a_rvalid     = 1'b0;
    b_rvalid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (a_ready | b_ready) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        gb_wen  = r_we;
        gb_rstb = ~r_we;
        if (r_we) begin
          w_state_next = ST_IDLE;
        end else if (RD_LAT == 0) begin
          w_sample     = 1'b1;
          w_state_next = ST_RESP;
        end else begin
          w_cnt_next   = LAT_M1;
          w_state_next = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (r_cnt == '0) begin
          w_sample     = 1'b1;
          w_state_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        // The pointer doubles as owner: it is only ever updated on a transfer.
        a_rvalid     = (r_last == OWN_A);
        b_rvalid     = (r_last == OWN_B);
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge gb_clk) begin
    if (!gb_rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= OWN_B;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (a_ready) begin
        r_last  <= OWN_A;
        r_we    <= a_we;
        r_addr  <= a_addr;
        r_wdata <= a_wdata;
      end else if (b_ready) begin
        r_last  <= OWN_B;
        r_we    <= b_we;
        r_addr  <= b_addr;
        r_wdata <= b_wdata;
      end
      if (w_sample) begin
        if (r_last == OWN_A) r_a_rdata <= gb_rdata;
        else                 r_b_rdata <= gb_rdata;
      end
    end
  end

endmodule

// File: doc/ghostbus_arbiter.md
# ghostbus_arbiter

Two-port arbiter that shares one ghostbus host port between two independent requesters (e.g. a host-interface bridge and an on-chip sequencer). It accepts one transaction at a time via valid/ready handshakes, drives the ghostbus strobes for exactly one cycle, waits a fixed read latency for `gb_rdata`, and returns read data to the requester that issued the read. It sits directly above the top-level ghostbus port of the decoded register/RAM tree.

## Interface

- `AW`, 24, address width
- `DW`, 32, data width
- `RD_LAT`, 2, cycles from `gb_rstb` high until `gb_rdata` is valid; legal range 0..15

- `gb_clk`  in  1  sole clock; all logic on rising edge
- `gb_rst_n`  in  1  reset, synchronous and active-low
- `a_valid`, `b_valid`  in  1  request present
- `a_we`, `b_we`  in  1  1 = write, 0 = read
- `a_addr`, `b_addr`  in  AW  request address
- `a_wdata`, `b_wdata`  in  DW  write data (ignored for reads)
- `a_ready`, `b_ready`  out  1  request accepted this cycle (valid & ready = transfer)
- `a_rvalid`, `b_rvalid`  out  1  one-cycle read-response pulse
- `a_rdata`, `b_rdata`  out  DW  read data, valid with `*_rvalid`
- `gb_addr`  out  AW  ghostbus address
- `gb_wdata`  out  DW  ghostbus write data
- `gb_wen`  out  1  ghostbus write strobe (one cycle)
- `gb_rstb`  out  1  ghostbus read strobe (one cycle)
- `gb_rdata`  in  DW  ghostbus read data

## Operation

- FSM states: IDLE, ISSUE, RWAIT, RESP.
- IDLE: `*_ready` is combinational from grant: only A valid -> A; only B valid -> B; both -> the port not granted last (round-robin pointer `last`). On transfer, register addr, wdata, we, owner; update `last`; go ISSUE.
- ISSUE (one cycle): `gb_addr`/`gb_wdata` from registers; `gb_wen`=we, `gb_rstb`=!we. Write -> IDLE. Read -> RWAIT with counter loaded RD_LAT (RD_LAT=0 -> RESP directly, sampling `gb_rdata` in the ISSUE cycle).
- RWAIT: decrement; when counter reaches 0 sample `gb_rdata` into the owner's rdata register, go RESP.
- RESP (one cycle): owner's `*_rvalid`=1; go IDLE.
- `gb_addr`/`gb_wdata` hold their last value outside ISSUE; `gb_wen`/`gb_rstb` 0 outside ISSUE.
- `*_rdata` holds last captured value until overwritten; non-owner's rdata never changes.
- Requester may drop valid before ready with no side effect; `*_ready` is never high outside IDLE, and never both high.
- No write response; writes are fire-and-forget.

## Timing

- Transfer in cycle T; strobe in T+1; write: next ready earliest T+2 (max write rate 1 per 2 cycles).
- Read: `gb_rdata` sampled at T+1+RD_LAT; `*_rvalid` at T+2+RD_LAT; next ready earliest T+3+RD_LAT.
- Reset (`gb_rst_n`=0 at an edge): state IDLE, `last`=B (so A wins first tie), all strobes/ready/rvalid 0, `gb_addr`, `gb_wdata`, `*_rdata` 0. Reset mid-read aborts with no rvalid; no strobe issued in the cycle after reset deasserts unless a new transfer occurs.

## Structure

- Package `ghostbus_arb_pkg`: state enum, owner enum (A/B), `RD_LAT` counter width constant (4 bits).
- Sub-module `ghostbus_rr_grant2`: combinational two-way round-robin pick from (`a_valid`, `b_valid`, `last`); registered pointer stays in the arbiter.

## Test plan

- Reset then A write addr 0x000010 data 0xDEADBEEF -> `gb_wen`=1 one cycle at T+1 with that addr/data; `gb_rstb` stays 0; no `a_rvalid`.
- A read addr 0x000004, RD_LAT=2, model drives 0x00000042 at T+3 -> `a_rvalid` at T+4 with 0x00000042; `b_rvalid` never asserts.
- A and B both valid continuously for 4 transactions -> grant order A, B, A, B; never both ready.
- B read in flight, A raises valid -> `a_ready` stays 0 until B's RESP passes; A accepted at T+5 earliest (RD_LAT=2).
- `gb_rst_n` low during RWAIT -> no rvalid, strobes 0, `*_rdata` 0; next A read proceeds normally.
- RD_LAT=0 build: read at T -> `gb_rstb` and sample at T+1, `a_rvalid` at T+2.
